// File: rtl/video_stream_adapter.sv
// video_stream_adapter: buffers a valid/ready RGB stream with an SOF marker
// and presents it on rgb, aligned to the hdmi cx/cy raster.
module video_stream_adapter #(
  parameter int          BIT_WIDTH  = 10,
  parameter int          BIT_HEIGHT = 10,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic                        clk_pixel,
  input  logic                        reset,
  input  logic [23:0]                 s_data,
  input  logic                        s_sof,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [BIT_WIDTH-1:0]        cx,
  input  logic [BIT_HEIGHT-1:0]       cy,
  input  logic [BIT_WIDTH-1:0]        screen_width,
  input  logic [BIT_HEIGHT-1:0]       screen_height,
  output logic [23:0]                 rgb,
  output logic                        locked,
  output logic                        underflow,
  output logic                        desync,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] SEEK   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state, state_nx;
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr, wptr_nx, rptr_nx;
  logic [AW:0]   level;
  logic [24:0]   head;
  logic [AW-1:0] wr_addr;
  logic          full, empty, accept, active, origin;
  logic          wr_en, pop, flush, uf_nx, ds_nx;

  assign level   = wptr - rptr;
  assign full    = (level == FULL_LVL);
  assign empty   = (wptr == rptr);
  assign head    = mem[rptr[AW-1:0]];
  assign active  = (cx < screen_width) && (cy < screen_height);
  assign origin  = (cx == '0) && (cy == '0);
  assign s_ready = (state == SEEK) || !full;
  assign accept  = s_valid && s_ready;

  assign locked     = (state == LOCKED);
  assign fifo_level = level;

  // Per-cycle decision: what to write, whether to pop, and the pixel to show
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    uf_nx    = 1'b0;
    ds_nx    = 1'b0;
    rgb      = FILL_COLOR;
    case (state)
      SEEK: begin
        wr_en = accept && s_sof;
        if (wr_en) state_nx = ARMED;
      end
      ARMED: begin
        wr_en = accept;
        if (origin && !empty) begin
          pop      = 1'b1;
          rgb      = head[23:0];
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        wr_en = accept;
        if (active) begin
          if (empty) begin
            uf_nx = 1'b1;
            flush = 1'b1;
          end else if (head[24] != origin) begin
            ds_nx = 1'b1;
            flush = 1'b1;
          end else begin
            pop = 1'b1;
            rgb = head[23:0];
          end
        end
      end
      default: state_nx = SEEK;
    endcase
    if (flush) begin
      // An SOF beat arriving while we flush starts the next frame directly
      wr_en    = accept && s_sof;
      wr_addr  = '0;
      rptr_nx  = '0;
      wptr_nx  = wr_en ? (AW+1)'(1) : '0;
      state_nx = wr_en ? ARMED : SEEK;
    end else begin
      wr_addr = wptr[AW-1:0];
      rptr_nx = rptr + {{AW{1'b0}}, pop};
      wptr_nx = wptr + {{AW{1'b0}}, wr_en};
    end
  end

  // FIFO storage, written with {sof, data}
  always_ff @(posedge clk_pixel) begin
    if (wr_en) mem[wr_addr] <= {s_sof, s_data};
  end

  // State, pointers and status pulses
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state     <= SEEK;
      wptr      <= '0;
      rptr      <= '0;
      underflow <= 1'b0;
      desync    <= 1'b0;
    end else begin
      state     <= state_nx;
      wptr      <= wptr_nx;
      rptr      <= rptr_nx;
      underflow <= uf_nx;
      desync    <= ds_nx;
    end
  end

endmodule

// File: tb/tb_video_stream_adapter.sv
// tb_video_stream_adapter: drives a 6x4 raster with a 4x2 screen and a
// randomized pixel stream, checking rgb and status against a frame model.
module tb_video_stream_adapter;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [23:0] s_data;
  logic        s_sof, s_valid, s_ready;
  logic [9:0]  cx, cy;
  logic [9:0]  screen_width  = 10'd4;
  logic [9:0]  screen_height = 10'd2;
  logic [23:0] rgb;
  logic        locked, underflow, desync;
  logic [2:0]  fifo_level;

  video_stream_adapter #(
    .BIT_WIDTH (10),
    .BIT_HEIGHT(10),
    .FIFO_DEPTH(4),
    .FILL_COLOR(24'h000000)
  ) dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .cx           (cx),
    .cy           (cy),
    .screen_width (screen_width),
    .screen_height(screen_height),
    .rgb          (rgb),
    .locked       (locked),
    .underflow    (underflow),
    .desync       (desync),
    .fifo_level   (fifo_level)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [24:0] src_q[$];
  bit          src_en;
  int          total, bad;
  logic [23:0] img [8];
  int          n_img;

  logic [23:0] o_rgb;
  logic        o_rdy, o_lk, o_uf, o_ds;
  logic [2:0]  o_lvl;
  logic [9:0]  o_x, o_y;

  // Frame model: pixel k of the frame is shown at raster index k while
  // inside the screen, and only the first n_img pixels are deliverable.
  function automatic logic [23:0] model_rgb(logic [9:0] x, logic [9:0] y);
    int k;
    if (x < 10'd4 && y < 10'd2) begin
      k = int'(y) * 4 + int'(x);
      if (k < n_img) return img[k];
    end
    return 24'h0;
  endfunction

  task automatic cyc();
    s_valid = src_en && (src_q.size() != 0);
    if (s_valid) {s_sof, s_data} = src_q[0];
    else begin
      s_sof  = 1'b0;
      s_data = 24'h0;
    end
    #4;
    o_rgb = rgb; o_rdy = s_ready; o_lk = locked;
    o_uf = underflow; o_ds = desync; o_lvl = fifo_level;
    o_x = cx; o_y = cy;
    @(posedge clk_pixel);
    if (s_valid && o_rdy) void'(src_q.pop_front());
    #1;
    if (cx == 10'd5) begin
      cx = 10'd0;
      cy = (cy == 10'd3) ? 10'd0 : cy + 10'd1;
    end else cx = cx + 10'd1;
  endtask

  task automatic goto(logic [9:0] x, logic [9:0] y);
    int n = 0;
    while (!(cx == x && cy == y) && n < 30) begin
      cyc();
      n++;
    end
    total++;
    if (n >= 30) begin
      bad++;
      $display("FAIL goto: raster never reached (%0d,%0d)", x, y);
    end
  endtask

  task automatic push_frame(int junk, logic [23:0] sof_mask);
    for (int i = 0; i < junk; i++) src_q.push_back({1'b0, 24'($urandom)});
    for (int k = 0; k < 8; k++) begin
      img[k] = 24'($urandom);
      src_q.push_back({sof_mask[k], img[k]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; src_en = 1'b0;
    cx = 10'd0; cy = 10'd0;
    cyc(); cyc();
    reset = 1'b0;
    goto(10'd0, 10'd0);
    for (int i = 0; i < 24; i++) begin
      cyc();
      total++;
      if (o_rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb (%0d,%0d): got %h want 000000", o_x, o_y, o_rgb); end
      total++;
      if (o_lk !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", o_lk); end
      total++;
      if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_rdy); end
      total++;
      if (o_lvl !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", o_lvl); end
    end
  endtask

  task automatic test_seek_discard();
    push_frame($urandom_range(1, 3), 24'h1);
    n_img = 8; src_en = 1'b1;
    for (int i = 0; i < 23; i++) begin
      cyc();
      total++;
      if (o_rgb !== 24'h0) begin bad++; $display("FAIL seek_rgb (%0d,%0d): got %h want 000000", o_x, o_y, o_rgb); end
      total++;
      if (o_lk !== 1'b0) begin bad++; $display("FAIL seek_locked (%0d,%0d): got %b want 0", o_x, o_y, o_lk); end
    end
  endtask

  task automatic test_backpressure();
    cyc();
    total++;
    if (o_lvl !== 3'd4) begin bad++; $display("FAIL bp_level: got %0d want 4", o_lvl); end
    total++;
    if (o_rdy !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", o_rdy); end
    total++;
    if (src_q.size() != 4) begin bad++; $display("FAIL bp_accepted: left %0d want 4", src_q.size()); end
  endtask

  task automatic test_lock(string tag);
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++;
      if (o_rgb !== model_rgb(o_x, o_y)) begin bad++; $display("FAIL %s_rgb (%0d,%0d): got %h want %h", tag, o_x, o_y, o_rgb, model_rgb(o_x, o_y)); end
      total++;
      if (o_lk !== (i > 0)) begin bad++; $display("FAIL %s_locked (%0d,%0d): got %b want %b", tag, o_x, o_y, o_lk, i > 0); end
      total++;
      if (o_uf !== 1'b0 || o_ds !== 1'b0) begin bad++; $display("FAIL %s_pulse: got uf=%b ds=%b want 0", tag, o_uf, o_ds); end
    end
  endtask

  task automatic test_underflow();
    int ufc = 0;
    img[0] = 24'($urandom); img[1] = 24'($urandom);
    src_q.push_back({1'b1, img[0]});
    src_q.push_back({1'b0, img[1]});
    n_img = 2;
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++;
      if (o_rgb !== 24'h0 || o_lk !== 1'b1) begin bad++; $display("FAIL uf_blank (%0d,%0d): got rgb=%h lk=%b want 000000 1", o_x, o_y, o_rgb, o_lk); end
    end
    for (int i = 0; i < 24; i++) begin
      cyc();
      ufc += int'(o_uf);
      total++;
      if (o_rgb !== model_rgb(o_x, o_y)) begin bad++; $display("FAIL uf_rgb (%0d,%0d): got %h want %h", o_x, o_y, o_rgb, model_rgb(o_x, o_y)); end
      if (i == 3) begin
        total++;
        if (o_uf !== 1'b1) begin bad++; $display("FAIL uf_pulse: got %b want 1", o_uf); end
        total++;
        if (o_lk !== 1'b0 || o_lvl !== 3'd0) begin bad++; $display("FAIL uf_state: got lk=%b lvl=%0d want 0 0", o_lk, o_lvl); end
      end
    end
    total++;
    if (ufc != 1) begin bad++; $display("FAIL uf_count: got %0d want 1", ufc); end
  endtask

  task automatic test_desync();
    int dsc = 0;
    push_frame(0, 24'h21);
    n_img = 5;
    for (int i = 0; i < 24; i++) begin
      cyc();
      total++;
      if (o_rgb !== 24'h0 || o_lk !== 1'b0) begin bad++; $display("FAIL ds_arm (%0d,%0d): got rgb=%h lk=%b want 000000 0", o_x, o_y, o_rgb, o_lk); end
    end
    for (int i = 0; i < 24; i++) begin
      cyc();
      dsc += int'(o_ds);
      total++;
      if (o_rgb !== model_rgb(o_x, o_y)) begin bad++; $display("FAIL ds_rgb (%0d,%0d): got %h want %h", o_x, o_y, o_rgb, model_rgb(o_x, o_y)); end
      if (i == 1) begin
        total++;
        if (o_lk !== 1'b1) begin bad++; $display("FAIL ds_relock: got %b want 1", o_lk); end
      end
      if (i == 8) begin
        total++;
        if (o_ds !== 1'b1 || o_lk !== 1'b0 || o_lvl !== 3'd0) begin bad++; $display("FAIL ds_state: got ds=%b lk=%b lvl=%0d want 1 0 0", o_ds, o_lk, o_lvl); end
      end
      total++;
      if (o_uf !== 1'b0) begin bad++; $display("FAIL ds_no_uf (%0d,%0d): got %b want 0", o_x, o_y, o_uf); end
    end
    total++;
    if (dsc != 1) begin bad++; $display("FAIL ds_count: got %0d want 1", dsc); end
  endtask

  task automatic test_mid_reset();
    push_frame(0, 24'h1);
    n_img = 8;
    repeat (24) cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (o_rgb !== model_rgb(o_x, o_y)) begin bad++; $display("FAIL mr_rgb (%0d,%0d): got %h want %h", o_x, o_y, o_rgb, model_rgb(o_x, o_y)); end
    end
    s_valid = src_en && (src_q.size() != 0);
    {s_sof, s_data} = src_q[0];
    #1;
    total++;
    if (rgb !== img[3] || fifo_level !== 3'd3 || locked !== 1'b1) begin bad++; $display("FAIL mr_before: got rgb=%h lvl=%0d lk=%b want %h 3 1", rgb, fifo_level, locked, img[3]); end
    #1 reset = 1'b1;
    #1;
    total++;
    if (rgb !== 24'h0 || locked !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL mr_async: got rgb=%h lk=%b lvl=%0d want 000000 0 0", rgb, locked, fifo_level); end
    total++;
    if (s_ready !== 1'b1 || underflow !== 1'b0 || desync !== 1'b0) begin bad++; $display("FAIL mr_async_flags: got rdy=%b uf=%b ds=%b want 1 0 0", s_ready, underflow, desync); end
    src_q.delete();
    src_en = 1'b0;
    s_valid = 1'b0;
    @(posedge clk_pixel);
    #1;
    cx = cx + 10'd1;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 24'($urandom)});
    src_en = 1'b1;
    goto(10'd0, 10'd0);
    for (int i = 0; i < 24; i++) begin
      cyc();
      total++;
      if (o_lk !== 1'b0 || o_lvl !== 3'd0 || o_rgb !== 24'h0) begin bad++; $display("FAIL mr_nosof (%0d,%0d): got lk=%b lvl=%0d rgb=%h want 0 0 000000", o_x, o_y, o_lk, o_lvl, o_rgb); end
    end
    push_frame(0, 24'h1);
    n_img = 8;
    repeat (24) cyc();
    test_lock("relock");
  endtask

  initial begin
    total = 0; bad = 0;
    s_data = 24'h0; s_sof = 1'b0; s_valid = 1'b0;
    test_reset();
    test_seek_discard();
    test_backpressure();
    test_lock("lock");
    test_underflow();
    test_desync();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
